// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the two requester ports and the unified memory port that the
//   arbiter sits between.
//   Ports (signals):
//     req[1:0], we[1:0]        per-port request / write enable
//     addr0, addr1             per-port byte address
//     wdata0, wdata1           per-port write data
//     gnt[1:0], done[1:0]      one-cycle accept / completion pulses
//     rdata                    data of the most recently completed read
//     busy                     arbiter is running an access
//     mem_adr, mem_writedata   address / write data towards memory
//     mem_we                   single-cycle memory write strobe
//     mem_readdata             data returned by memory
//   Modports: slave = arbiter side, master = requesters + memory side.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [1:0]        req;
   logic [1:0]        we;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        gnt;
   logic [1:0]        done;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic [ADDR_W-1:0] mem_adr;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_readdata;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, mem_readdata,
      output gnt, done, rdata, busy, mem_adr, mem_writedata, mem_we
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, mem_readdata,
      input  gnt, done, rdata, busy, mem_adr, mem_writedata, mem_we
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between port 0 (processor) and port 1
//   (loader/DMA). One transaction outstanding at a time, round-robin on
//   ties, fixed MEM_LAT-cycle accesses.
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous, active-high
//     bus        mem_port_arbiter_if.slave (requester + memory signals)
//     state_dbg  current FSM state (0 = IDLE, 1 = ACCESS)
//
//   Handshake: a requester raises req[p] with we/addr/wdata stable and
//   holds them until it sees gnt[p] (the inputs were latched on the edge
//   that raised gnt). done[p] pulses once, MEM_LAT cycles after gnt[p];
//   for a read, rdata is valid from that cycle on. A req[p] still high
//   after gnt[p] is a fresh request. req is not looked at during ACCESS.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_port_arbiter_if.slave    bus,
   output logic                 state_dbg
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             last_granted;
   logic             owner;
   logic             we_q;
   logic             winner;
   logic             take;
   logic             finish;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: arbitration in IDLE, latency count in ACCESS
   always_comb begin
      state_nxt = state;
      winner    = 1'b0;
      take      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req != 2'b00) begin
               take      = 1'b1;
               state_nxt = ACCESS;
               case (bus.req)
                  2'b01:   winner = 1'b0;
                  2'b10:   winner = 1'b1;
                  // Tie: the port that did not win last time
                  default: winner = ~last_granted;
               endcase
            end
         end
         ACCESS: begin
            // cnt counts completed ACCESS cycles; the last one is MEM_LAT-1
            if (cnt == CNT_W'(MEM_LAT - 1)) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.gnt           <= 2'b00;
         bus.done          <= 2'b00;
         bus.mem_we        <= 1'b0;
         bus.mem_adr       <= '0;
         bus.mem_writedata <= '0;
         bus.rdata         <= '0;
         cnt               <= '0;
         last_granted      <= 1'b1;
         owner             <= 1'b0;
         we_q              <= 1'b0;
      end else begin
         // Pulses default low; mem_we is therefore a one-cycle strobe
         bus.gnt    <= 2'b00;
         bus.done   <= 2'b00;
         bus.mem_we <= 1'b0;
         if (take) begin
            bus.mem_adr       <= winner ? bus.addr1  : bus.addr0;
            bus.mem_writedata <= winner ? bus.wdata1 : bus.wdata0;
            we_q              <= bus.we[winner];
            bus.mem_we        <= bus.we[winner];
            owner             <= winner;
            last_granted      <= winner;
            bus.gnt           <= winner ? 2'b10 : 2'b01;
            cnt               <= '0;
         end
         if (state == ACCESS) begin
            cnt <= cnt + 1'b1;
            if (finish) begin
               if (!we_q) begin
                  bus.rdata <= bus.mem_readdata;
               end
               bus.done <= owner ? 2'b10 : 2'b01;
            end
         end
      end
   end

   assign bus.busy  = (state == ACCESS);
   assign state_dbg = (state == ACCESS);

endmodule
